// File: rtl/sregn_pipe.sv
// sregn_pipe: depth-stage enabled delay line with per-stage valid bits,
// synchronous flush and an occupancy counter. Data registers may be left
// without reset so wide pipelines stay reset-free in the datapath.

// One pipeline stage: a data register plus its valid bit.
module sregn_pipe_stage #(
  parameter int width      = 32,
  parameter bit reset_data = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             clr,
  input  logic [width-1:0] d_in,
  input  logic             v_in,
  output logic [width-1:0] d_out,
  output logic             v_out
);

  // Valid bit: always reset, cleared by flush, shifted on advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    v_out <= 1'b0;
    else if (clr) v_out <= 1'b0;
    else if (adv) v_out <= v_in;
  end

  // Data moves on every advance whether or not the item is valid; a flush
  // leaves it alone because only the valid bits carry meaning.
  generate
    if (reset_data) begin : g_drst
      // Data register with async clear.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)    d_out <= '0;
        else if (adv) d_out <= d_in;
      end
    end else begin : g_dnrst
      // Data register without reset.
      always_ff @(posedge clk) begin
        if (adv) d_out <= d_in;
      end
    end
  endgenerate

endmodule

module sregn_pipe #(
  parameter  int width      = 32,
  parameter  int depth      = 4,
  parameter  bit reset_data = 1'b0,
  localparam int count_w    = $clog2(depth + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               flush,
  input  logic [width-1:0]   i0,
  input  logic               i0_valid,
  output logic [width-1:0]   o0,
  output logic               o0_valid,
  output logic [count_w-1:0] count,
  output logic               empty
);

  typedef logic [count_w:0] sum_t;

  // Index 0 is the input; index k is the output of stage k-1.
  logic [depth:0][width-1:0] dat_pipe;
  logic [depth:0]            vld_pipe;
  logic [count_w-1:0]        cnt;
  sum_t                      cnt_sum;
  logic                      adv;

  // Flush wins over enable, so an advance only happens without flush.
  assign adv         = enable & ~flush;
  assign dat_pipe[0] = i0;
  assign vld_pipe[0] = i0_valid;

  generate
    for (genvar k = 0; k < depth; k++) begin : g_stage
      sregn_pipe_stage #(
        .width      (width),
        .reset_data (reset_data)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .adv   (adv),
        .clr   (flush),
        .d_in  (dat_pipe[k]),
        .v_in  (vld_pipe[k]),
        .d_out (dat_pipe[k+1]),
        .v_out (vld_pipe[k+1])
      );
    end
  endgenerate

  // One extra bit of headroom so the add-then-subtract never wraps; the
  // result is always within 0..depth so the top bit is dropped.
  always_comb begin
    cnt_sum = sum_t'(cnt) + sum_t'(i0_valid) - sum_t'(vld_pipe[depth]);
  end

  // Occupancy counter tracks the number of valid stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (flush) cnt <= '0;
    else if (adv)   cnt <= cnt_sum[count_w-1:0];
  end

  assign o0       = dat_pipe[depth];
  assign o0_valid = vld_pipe[depth];
  assign count    = cnt;
  assign empty    = (cnt == '0);

endmodule
